// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson sequence checker.
package johnson_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, SLIP} state_e;

  function automatic int unsigned next_index(input int unsigned idx,
                                             input int unsigned seq_len);
    return (idx + 1 >= seq_len) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Maps a Johnson code to {legal, index}; purely combinational.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDX_W-1:0] index
);

  localparam logic [WIDTH-1:0] ONES = '1;

  always_comb begin
    legal = 1'b0;
    index = '0;
    // Filling phase: k ones packed against the MSB.
    for (int k = 0; k <= WIDTH; k++) begin
      if (code == ~(ONES >> k)) begin
        legal = 1'b1;
        index = IDX_W'(k);
      end
    end
    // Draining phase: ones left in the low WIDTH-k bits.
    for (int k = 1; k < WIDTH; k++) begin
      if (code == (ONES >> k)) begin
        legal = 1'b1;
        index = IDX_W'(WIDTH + k);
      end
    end
  end

endmodule

// File: rtl/johnson_checker.sv
// Receive-side Johnson sequence checker: decode, order check, lock/flywheel FSM
// and saturating error counter. All outputs registered.
module johnson_checker
  import johnson_pkg::*;
#(
  parameter  int WIDTH      = WIDTH_DEF,
  parameter  int LOCK_CNT   = 3,
  parameter  int UNLOCK_CNT = 2,
  parameter  int ERR_W      = 8,
  localparam int IDX_W      = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             code_valid,
  input  logic [WIDTH-1:0] code,
  input  logic             clear_err,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             legal,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int          GC_W    = $clog2(LOCK_CNT + 1);
  localparam int          BC_W    = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned SEQ_LEN = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] prev_q, prev_d;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
  logic [BC_W-1:0]  bad_cnt_q, bad_cnt_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             index_valid_q, index_valid_d;
  logic             legal_q, legal_d;
  logic             locked_q, locked_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             dec_legal;
  logic [IDX_W-1:0] dec_index;
  logic [IDX_W-1:0] exp_idx;
  logic             good;
  logic             err_inc;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (code),
    .legal (dec_legal),
    .index (dec_index)
  );

  assign exp_idx = IDX_W'(next_index(32'(prev_q), SEQ_LEN));
  assign good    = dec_legal && (dec_index == exp_idx);

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    index_d       = index_q;
    legal_d       = legal_q;
    index_valid_d = 1'b0;
    err_inc       = 1'b0;

    if (code_valid) begin
      legal_d       = dec_legal;
      index_valid_d = dec_legal;
      if (dec_legal) index_d = dec_index;

      unique case (state_q)
        HUNT: begin
          if (dec_legal) begin
            prev_d     = dec_index;
            good_cnt_d = '0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          if (good) begin
            prev_d     = dec_index;
            good_cnt_d = good_cnt_q + GC_W'(1);
            if (good_cnt_d == GC_W'(LOCK_CNT)) state_d = LOCKED;
          end else if (dec_legal) begin
            prev_d     = dec_index;
            good_cnt_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: expectation advances whether or not the sample matched.
          prev_d = exp_idx;
          if (!good) begin
            err_inc   = 1'b1;
            bad_cnt_d = BC_W'(1);
            state_d   = SLIP;
          end
        end
        SLIP: begin
          prev_d = exp_idx;
          if (good) begin
            bad_cnt_d = '0;
            state_d   = LOCKED;
          end else begin
            err_inc   = 1'b1;
            bad_cnt_d = bad_cnt_q + BC_W'(1);
            if (bad_cnt_d == BC_W'(UNLOCK_CNT)) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    seq_err_d = err_inc;
    locked_d  = (state_d == LOCKED) || (state_d == SLIP);

    err_count_d = err_count_q;
    if (clear_err)                          err_count_d = '0;
    else if (err_inc && err_count_q != '1)  err_count_d = err_count_q + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= HUNT;
      prev_q        <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      legal_q       <= 1'b0;
      locked_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      legal_q       <= legal_d;
      locked_q      <= locked_d;
      seq_err_q     <= seq_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign legal       = legal_q;
  assign locked      = locked_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_checker.sv
// Bench for johnson_checker: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_johnson_checker;

  logic       clk = 1'b0;
  logic       clr;
  logic       code_valid;
  logic [3:0] code;
  logic       clear_err;
  logic [2:0] index;
  logic       index_valid;
  logic       legal;
  logic       locked;
  logic       seq_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  johnson_checker #(.WIDTH(4), .LOCK_CNT(3), .UNLOCK_CNT(2), .ERR_W(8)) dut (
    .clk         (clk),
    .clr         (clr),
    .code_valid  (code_valid),
    .code        (code),
    .clear_err   (clear_err),
    .index       (index),
    .index_valid (index_valid),
    .legal       (legal),
    .locked      (locked),
    .seq_err     (seq_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Johnson codes generated by shifting the inverted LSB into the MSB.
  function automatic logic [3:0] jcode(input int i);
    logic [3:0] s;
    s = 4'b0000;
    for (int n = 0; n < i; n++) s = {~s[0], s[3:1]};
    return s;
  endfunction

  function automatic int jidx(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (jcode(i) == c) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Behavioural model: mode 0 hunt, 1 verify, 2 locked, 3 slip.
  int m_mode = 0, m_prev = 0, m_good = 0, m_bad = 0;
  int m_index = 0, m_iv = 0, m_legal = 0, m_locked = 0, m_seq = 0, m_err = 0;
  int s_idx, s_exp;
  bit s_good, s_err;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_mode = 0; m_prev = 0; m_good = 0; m_bad = 0;
      m_index = 0; m_iv = 0; m_legal = 0; m_locked = 0; m_seq = 0; m_err = 0;
    end else begin
      s_err = 1'b0;
      m_iv  = 0;
      if (code_valid) begin
        s_idx   = jidx(code);
        s_exp   = (m_prev + 1) % 8;
        s_good  = (s_idx == s_exp);
        m_legal = (s_idx >= 0);
        m_iv    = m_legal;
        if (m_legal) m_index = s_idx;
        case (m_mode)
          0: if (m_legal) begin m_prev = s_idx; m_good = 0; m_mode = 1; end
          1: begin
            if (s_good) begin
              m_prev = s_idx; m_good++;
              if (m_good == 3) m_mode = 2;
            end else if (m_legal) begin
              m_prev = s_idx; m_good = 0;
            end else m_mode = 0;
          end
          default: begin
            m_prev = s_exp;
            if (s_good) begin m_bad = 0; m_mode = 2; end
            else begin
              s_err = 1'b1;
              m_bad = (m_mode == 2) ? 1 : m_bad + 1;
              m_mode = (m_bad >= 2) ? 0 : 3;
            end
          end
        endcase
      end
      m_seq    = s_err;
      m_locked = (m_mode >= 2);
      if (clear_err) m_err = 0;
      else if (s_err && m_err < 255) m_err++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && !clr) begin
      chk("m_index",       int'(index),       m_index);
      chk("m_index_valid", int'(index_valid), m_iv);
      chk("m_legal",       int'(legal),       m_legal);
      chk("m_locked",      int'(locked),      m_locked);
      chk("m_seq_err",     int'(seq_err),     m_seq);
      chk("m_err_count",   int'(err_count),   m_err);
    end
  end

  task automatic send(input logic [3:0] c);
    @(negedge clk);
    code_valid = 1'b1;
    code       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    code_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int e;
  int p;
  int r;

  initial begin
    clr = 1'b1; code_valid = 1'b0; code = 4'b0000; clear_err = 1'b0;
    #1;
    chk("rst_index", int'(index), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_legal", int'(legal), 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk_en = 1'b1;

    // Lock acquisition
    send(4'b0000); chk("acq_idx0", int'(index), 0);
    send(4'b1000); chk("acq_idx1", int'(index), 1);
    send(4'b1100); chk("acq_idx2", int'(index), 2); chk("acq_nolock", int'(locked), 0);
    send(4'b1110); chk("acq_idx3", int'(index), 3); chk("acq_lock", int'(locked), 1);
    chk("acq_err", int'(err_count), 0);

    // Wrap through 7 -> 0
    send(4'b1111); chk("wrap_idx4", int'(index), 4);
    send(4'b0111); chk("wrap_idx5", int'(index), 5);
    send(4'b0011); chk("wrap_idx6", int'(index), 6);
    send(4'b0001); chk("wrap_idx7", int'(index), 7);
    send(4'b0000); chk("wrap_idx0", int'(index), 0); chk("wrap_seq", int'(seq_err), 0);
    chk("wrap_lock", int'(locked), 1);

    // Single glitch at expected 5
    for (int i = 1; i <= 4; i++) send(jcode(i));
    send(4'b0101);
    chk("gl_legal", int'(legal), 0); chk("gl_seq", int'(seq_err), 1);
    chk("gl_err", int'(err_count), 1); chk("gl_lock", int'(locked), 1);
    chk("gl_idx_hold", int'(index), 4);
    send(4'b0011);
    chk("gl_idx6", int'(index), 6); chk("gl_seq2", int'(seq_err), 0);
    chk("gl_lock2", int'(locked), 1);

    // Clear, then loss of lock
    clear_err = 1'b1; idle(); clear_err = 1'b0;
    chk("clr_err", int'(err_count), 0);
    send(jcode(1)); chk("loss_seq1", int'(seq_err), 1); chk("loss_lock1", int'(locked), 1);
    send(jcode(2)); chk("loss_seq2", int'(seq_err), 1); chk("loss_lock2", int'(locked), 0);
    chk("loss_err", int'(err_count), 2);
    for (int i = 0; i < 3; i++) send(jcode(i));
    chk("relock_not_yet", int'(locked), 0);
    send(jcode(3)); chk("relock", int'(locked), 1);

    // Valid gaps
    repeat (3) begin
      idle();
      chk("gap_iv", int'(index_valid), 0); chk("gap_lock", int'(locked), 1);
    end
    send(jcode(4)); chk("gap_resume_seq", int'(seq_err), 0); chk("gap_resume_idx", int'(index), 4);

    // Saturation: alternate illegal glitch and correct successor
    e = 4;
    for (int n = 0; n < 255; n++) begin
      send(4'b0101); e = (e + 1) % 8;
      send(jcode((e + 1) % 8)); e = (e + 1) % 8;
    end
    chk("sat_255", int'(err_count), 255);
    send(4'b0101); e = (e + 1) % 8;
    chk("sat_hold", int'(err_count), 255); chk("sat_seq", int'(seq_err), 1);
    send(jcode((e + 1) % 8)); e = (e + 1) % 8;
    clear_err = 1'b1; send(4'b0101); clear_err = 1'b0;
    chk("clr_wins", int'(err_count), 0); chk("clr_wins_seq", int'(seq_err), 1);
    chk("clr_wins_lock", int'(locked), 1);

    // Asynchronous reset mid-lock
    @(negedge clk); #2;
    clr = 1'b1;
    #1;
    chk("async_lock", int'(locked), 0); chk("async_idx", int'(index), 0);
    chk("async_legal", int'(legal), 0); chk("async_seq", int'(seq_err), 0);
    chk("async_err", int'(err_count), 0); chk("async_iv", int'(index_valid), 0);
    @(negedge clk);
    clr = 1'b0;

    // Randomized traffic
    p = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      clear_err = (r < 3);
      if (r < 15) code_valid = 1'b0;
      else begin
        code_valid = 1'b1;
        if (r < 25) code = 4'($urandom_range(0, 15));
        else begin
          if (r < 28) p = $urandom_range(0, 7);
          p = (p + 1) % 8;
          code = jcode(p);
        end
      end
    end
    @(negedge clk);
    code_valid = 1'b0; clear_err = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/johnson_checker.md
Name: johnson_checker

Overview:
- Receive-side checker for the 4-bit Johnson sequence produced by the team's synchronous JK sequence counter.
- Legal sequence, index 0..7: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, then back to 0000.
- Decodes each sampled code to a binary index, validates that codes are legal and arrive in order, and runs a lock/flywheel FSM.
- Counts sequence errors for status readout.
- Sits on the consumer side of the counter output, at board or bench level.

Parameters:
- WIDTH, 4: Johnson register width. Sequence length is 2*WIDTH.
- LOCK_CNT, 3: consecutive correct successors after the seed sample that are needed to declare lock.
- UNLOCK_CNT, 2: consecutive bad samples that drop lock.
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  Rising-edge clock.
- clr  input  1  Asynchronous active-high reset.
- code_valid  input  1  code is sampled on this cycle.
- code  input  WIDTH  Johnson code under check.
- clear_err  input  1  Synchronous clear of err_count.
- index  output  $clog2(2*WIDTH)  Decoded index of the last legal sample.
- index_valid  output  1  Registered (code_valid & legal).
- legal  output  1  Last sample was a legal Johnson code.
- locked  output  1  FSM is in LOCKED or SLIP.
- seq_err  output  1  One-cycle pulse on an error while locked.
- err_count  output  ERR_W  Saturating error count.

Behaviour:
- Decode rule:
  - Legal codes are k ones filled from the MSB (k = 0..WIDTH), giving index k.
  - Or ones remaining in the low WIDTH-k' bits, giving index WIDTH+k' (k' = 1..WIDTH-1).
  - Any other pattern is illegal; index holds its previous value.
- Latency: a sample taken at edge N updates index, index_valid, legal, locked, seq_err and err_count at edge N+1. All outputs are registered.
- With code_valid=0:
  - No FSM change, expected index not advanced, counters held.
  - index_valid=0 and seq_err=0; legal and index hold.
- The expected successor is (prev+1) mod 2*WIDTH. 7→0 is a correct transition.
- FSM states are HUNT, VERIFY, LOCKED, SLIP. A "good" sample means legal and index == expected.
  - HUNT: a legal sample seeds prev and moves to VERIFY with good_cnt=0. An illegal sample stays in HUNT.
  - VERIFY:
    - Good: good_cnt+1, prev=index; when good_cnt reaches LOCK_CNT, go to LOCKED.
    - Bad but legal: reseed prev, good_cnt=0, stay in VERIFY.
    - Illegal: go to HUNT.
    - No errors are counted in VERIFY.
  - LOCKED:
    - Good: stay.
    - Bad: seq_err=1, err_count+1, bad_cnt=1, go to SLIP. The expected index still advances (flywheel).
  - SLIP:
    - Good: go to LOCKED, bad_cnt=0.
    - Bad: seq_err=1, err_count+1, bad_cnt+1. When bad_cnt reaches UNLOCK_CNT, go to HUNT and locked falls at the same edge.
    - The expected index advances on every valid sample.
- err_count saturates at all-ones and never wraps. If clear_err coincides with an increment, clear wins and the result is 0.
- Reset (asynchronous, immediate):
  - State HUNT, all counters 0.
  - index=0, index_valid=0, legal=0, locked=0, seq_err=0, err_count=0.
  - clr asserted mid-lock discards lock with no error pulse.

Decomposition:
- Shared package johnson_pkg holds:
  - the state enum (HUNT, VERIFY, LOCKED, SLIP);
  - the WIDTH default;
  - a function computing the successor index.
- One combinational sub-module, johnson_decode, maps code to {legal, index}. It is reusable by the generator bench model.

Test Plan:
- Lock acquisition: after reset, feed valid 0000, 1000, 1100, 1110 on consecutive cycles → index 0, 1, 2, 3. locked=1 one cycle after the 1110 sample; err_count=0.
- Wrap: while locked, continue 1111, 0111, 0011, 0001, 0000 → index 4, 5, 6, 7, 0 with no seq_err. 7→0 is accepted.
- Single glitch: while locked with expected 5, feed 0101 then 0011 →
  - after the illegal sample: legal=0, seq_err pulse, err_count=1, locked stays 1;
  - 0011 (index 6) is accepted as good, state returns to LOCKED.
- Loss of lock: while locked, two consecutive wrong legal codes → two seq_err pulses, err_count=2, locked=0 after the second. Then 4 correct codes relock.
- Valid gaps: while locked, drop code_valid for 3 cycles, then resume with the next expected code → no seq_err, locked stays 1, index_valid=0 during the gap.
- Reset and clear:
  - Assert clr asynchronously mid-lock → all outputs 0 without waiting for a clock edge.
  - With err_count=255 and another error → count stays 255.
  - clear_err on the same cycle as an error → err_count=0.
